// File: rtl/ysyx_22050039_mem_pkg.sv
// Shared types and defaults for the IFU/LSU memory arbiter.
package ysyx_22050039_mem_pkg;

  localparam int unsigned XLEN_DEF       = 64;
  localparam int unsigned INST_LEN_DEF   = 32;
  localparam int unsigned STARVE_MAX_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } ls_size_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;

  // Byte-enable pattern for an access of the given size at offset 0.
  function automatic logic [7:0] lane_bits(input logic [1:0] size);
    case (ls_size_e'(size))
      SZ_BYTE: return 8'h01;
      SZ_HALF: return 8'h03;
      SZ_WORD: return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050039_lane_align.sv
// Byte-lane steering: store data/mask placement, load data extraction, alignment check.
module ysyx_22050039_lane_align
  import ysyx_22050039_mem_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [1:0]      size,
  input  logic [2:0]      addr_off,
  input  logic [XLEN-1:0] wdata,
  input  logic [2:0]      rd_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_c,
  output logic [7:0]      wmask_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            misalign_c
);

  logic [7:0] lanes;
  logic [2:0] align_mask;

  assign lanes      = lane_bits(size);
  assign align_mask = 3'((4'(1) << size) - 4'(1));

  assign misalign_c = |(addr_off & align_mask);
  assign wmask_c    = lanes << addr_off;
  assign wdata_c    = wdata << {addr_off, 3'b000};
  assign rdata_c    = rdata >> {rd_off, 3'b000};

endmodule

// File: rtl/ysyx_22050039_mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store units,
// LSU-priority with a bounded starvation guard for the IFU.
module ysyx_22050039_mem_arb
  import ysyx_22050039_mem_pkg::*;
#(
  parameter int unsigned XLEN       = XLEN_DEF,
  parameter int unsigned INST_LEN   = INST_LEN_DEF,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [XLEN-1:0]     if_addr,
  output logic                if_rsp_valid,
  output logic [INST_LEN-1:0] if_rsp_inst,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic                ls_we,
  input  logic [1:0]          ls_size,
  input  logic [XLEN-1:0]     ls_addr,
  input  logic [XLEN-1:0]     ls_wdata,
  output logic                ls_rsp_valid,
  output logic [XLEN-1:0]     ls_rsp_rdata,
  output logic                ls_rsp_misalign,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [XLEN-1:0]     mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [7:0]          mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [XLEN-1:0]     mem_rdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  arb_state_e       state_q, state_d;
  owner_e           owner_q;
  logic [CNT_W-1:0] starve_q;
  logic             inst_hi_q;
  logic [2:0]       rd_off_q;
  logic             grant_if, grant_ls, starve_full;
  logic [XLEN-1:0]  wdata_sh, rdata_sh;
  logic [7:0]       wmask_sh;
  logic             misalign;
  logic             unused_if_lsb;

  assign unused_if_lsb = ^if_addr[1:0];

  ysyx_22050039_lane_align #(.XLEN(XLEN)) u_lane (
    .size       (ls_size),
    .addr_off   (ls_addr[2:0]),
    .wdata      (ls_wdata),
    .rd_off     (rd_off_q),
    .rdata      (mem_rdata),
    .wdata_c    (wdata_sh),
    .wmask_c    (wmask_sh),
    .rdata_c    (rdata_sh),
    .misalign_c (misalign)
  );

  assign starve_full = (starve_q == CNT_W'(STARVE_MAX));

  // Next state and grant decode; grants only from IDLE while out of reset.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_ls = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rst) begin
          if (ls_req_valid && !(if_req_valid && starve_full)) begin
            grant_ls = 1'b1;
            state_d  = misalign ? ST_RESP : ST_REQ;
          end else if (if_req_valid) begin
            grant_if = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT: if (mem_rsp_valid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign if_req_ready  = grant_if;
  assign ls_req_ready  = grant_ls;
  assign mem_req_valid = (state_q == ST_REQ);
  assign if_rsp_valid  = (state_q == ST_RESP) && (owner_q == OWN_IFU);
  assign ls_rsp_valid  = (state_q == ST_RESP) && (owner_q == OWN_LSU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Command latch at grant, response capture on completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q         <= OWN_IFU;
      starve_q        <= '0;
      inst_hi_q       <= 1'b0;
      rd_off_q        <= '0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      mem_wmask       <= '0;
      if_rsp_inst     <= '0;
      ls_rsp_rdata    <= '0;
      ls_rsp_misalign <= 1'b0;
    end else begin
      if (grant_ls) begin
        owner_q <= OWN_LSU;
        if (if_req_valid && !starve_full) starve_q <= starve_q + CNT_W'(1);
        if (misalign) begin
          ls_rsp_misalign <= 1'b1;
          ls_rsp_rdata    <= '0;
        end else begin
          rd_off_q  <= ls_addr[2:0];
          mem_we    <= ls_we;
          mem_addr  <= {ls_addr[XLEN-1:3], 3'b000};
          mem_wdata <= ls_we ? wdata_sh : '0;
          mem_wmask <= ls_we ? wmask_sh : 8'h00;
        end
      end
      if (grant_if) begin
        owner_q   <= OWN_IFU;
        starve_q  <= '0;
        inst_hi_q <= if_addr[2];
        mem_we    <= 1'b0;
        mem_addr  <= {if_addr[XLEN-1:3], 3'b000};
        mem_wdata <= '0;
        mem_wmask <= 8'h00;
      end
      if ((state_q == ST_WAIT) && mem_rsp_valid) begin
        if (owner_q == OWN_IFU) begin
          if_rsp_inst <= inst_hi_q ? mem_rdata[2*INST_LEN-1:INST_LEN]
                                   : mem_rdata[INST_LEN-1:0];
        end else begin
          ls_rsp_misalign <= 1'b0;
          ls_rsp_rdata    <= mem_we ? '0 : rdata_sh;
        end
      end
    end
  end

endmodule
